// File: rtl/microsequencer_if.sv
// Bundle of the microsequencer's control inputs and registered status outputs.
// The master side (controller/bench) drives the next-address controls; the slave (sequencer) reports state.
interface microsequencer_if #(
  parameter int STATE_W = 7,
  parameter int NCOND   = 4,
  parameter int DEPTH   = 4
);
  localparam int CSEL_W = $clog2(NCOND);
  localparam int SP_W   = $clog2(DEPTH + 1);

  // ld is a plain advance enable: each rising clk with ld=1 consumes one
  // n_op; with ld=0 every piece of sequencer state holds. There is no ready.
  logic                ld;
  logic [3:0]          n_op;
  logic [NCOND-1:0]    cond_in;
  logic [CSEL_W-1:0]   cond_sel;
  logic                inv;
  logic [STATE_W-1:0]  enc;
  logic [STATE_W-1:0]  cr;
  logic [STATE_W-1:0]  state;
  logic [SP_W-1:0]     sp;
  logic                ovf;
  logic                unf;
  logic                sts;

  modport master (
    output ld, n_op, cond_in, cond_sel, inv, enc, cr,
    input  state, sp, ovf, unf, sts
  );

  modport slave (
    input  ld, n_op, cond_in, cond_sel, inv, enc, cr,
    output state, sp, ovf, unf, sts
  );
endinterface

// File: rtl/microsequencer.sv
// Microprogram sequencer: next-address selection with condition test and a
// return-address stack with sticky overflow/underflow flags.
module microsequencer #(
  parameter int STATE_W    = 7,
  parameter int NCOND      = 4,
  parameter int DEPTH      = 4,
  parameter int FETCH_ADDR = 1,
  parameter int RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  microsequencer_if.slave   bus
);
  localparam int SP_W = $clog2(DEPTH + 1);

  localparam logic [3:0] OP_ENC       = 4'h0;
  localparam logic [3:0] OP_FETCH     = 4'h1;
  localparam logic [3:0] OP_CR        = 4'h2;
  localparam logic [3:0] OP_INC       = 4'h3;
  localparam logic [3:0] OP_ENC_CR    = 4'h4;
  localparam logic [3:0] OP_FETCH_CR  = 4'h5;
  localparam logic [3:0] OP_INC_FETCH = 4'h6;
  localparam logic [3:0] OP_BRANCH    = 4'h7;
  localparam logic [3:0] OP_CALL      = 4'h8;
  localparam logic [3:0] OP_CALL_C    = 4'h9;
  localparam logic [3:0] OP_RET       = 4'hA;
  localparam logic [3:0] OP_RET_C     = 4'hB;

  localparam logic [STATE_W-1:0] FETCH_V = STATE_W'(FETCH_ADDR);
  localparam logic [STATE_W-1:0] RESET_V = STATE_W'(RESET_ADDR);
  localparam logic [SP_W-1:0]    SP_FULL = SP_W'(DEPTH);

  logic [STATE_W-1:0] state_q, state_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [STATE_W-1:0] stack_q [DEPTH];
  logic [STATE_W-1:0] stack_d [DEPTH];

  logic               sts;
  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] top;
  logic [STATE_W-1:0] op_next;
  logic               do_call;
  logic               do_ret;

  assign sts = bus.cond_in[bus.cond_sel] ^ bus.inv;
  assign inc = state_q + STATE_W'(1);

  // Entry below sp is the top of stack; sp==0 leaves top unused.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    op_next = inc;
    do_call = 1'b0;
    do_ret  = 1'b0;
    case (bus.n_op)
      OP_ENC:       op_next = bus.enc;
      OP_FETCH:     op_next = FETCH_V;
      OP_CR:        op_next = bus.cr;
      OP_INC:       op_next = inc;
      OP_ENC_CR:    op_next = sts ? bus.enc : bus.cr;
      OP_FETCH_CR:  op_next = sts ? FETCH_V : bus.cr;
      OP_INC_FETCH: op_next = sts ? inc : FETCH_V;
      OP_BRANCH:    op_next = sts ? bus.cr : inc;
      OP_CALL:      do_call = 1'b1;
      OP_CALL_C:    do_call = sts;
      OP_RET:       do_ret  = 1'b1;
      OP_RET_C:     do_ret  = sts;
      default:      op_next = inc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;
    if (bus.ld) begin
      state_d = op_next;
      if (do_call) begin
        state_d = bus.cr;
        // A call into a full stack still jumps; only the return address is lost.
        if (sp_q == SP_FULL) begin
          ovf_d = 1'b1;
        end else begin
          sp_d = sp_q + SP_W'(1);
          for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SP_W'(i)) stack_d[i] = inc;
          end
        end
      end
      if (do_ret) begin
        if (sp_q == '0) begin
          state_d = FETCH_V;
          unf_d   = 1'b1;
        end else begin
          state_d = top;
          sp_d    = sp_q - SP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_V;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents carry no reset; validity is defined by sp alone.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.state = state_q;
  assign bus.sp    = sp_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  assign bus.sts   = sts;
endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: queue-based reference model, per-cycle compare,
// directed literal checks and a randomized phase with occasional mid-cycle resets.
module tb_microsequencer;
  localparam int STATE_W    = 7;
  localparam int NCOND      = 4;
  localparam int DEPTH      = 4;
  localparam int FETCH_ADDR = 1;
  localparam int RESET_ADDR = 0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  microsequencer_if #(.STATE_W(STATE_W), .NCOND(NCOND), .DEPTH(DEPTH)) bus();

  microsequencer #(
    .STATE_W(STATE_W), .NCOND(NCOND), .DEPTH(DEPTH),
    .FETCH_ADDR(FETCH_ADDR), .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int  m_state = RESET_ADDR;
  int  m_stack[$];
  bit  m_ovf = 1'b0;
  bit  m_unf = 1'b0;
  logic [STATE_W-1:0] exp_q[$];

  logic [3:0] d_cond = 4'd0;
  logic [1:0] d_sel  = 2'd0;
  logic       d_inv  = 1'b0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_state = RESET_ADDR;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_edge(logic ld, logic [3:0] op, logic [3:0] ci,
                                     logic [1:0] cs, logic iv, int en, int c);
    bit s;
    int nxt;
    bit call;
    bit ret;
    s    = ci[cs] ^ iv;
    nxt  = (m_state + 1) % (1 << STATE_W);
    call = 1'b0;
    ret  = 1'b0;
    if (!ld) return;
    case (op)
      4'd0: m_state = en;
      4'd1: m_state = FETCH_ADDR;
      4'd2: m_state = c;
      4'd4: m_state = s ? en : c;
      4'd5: m_state = s ? FETCH_ADDR : c;
      4'd6: m_state = s ? nxt : FETCH_ADDR;
      4'd7: m_state = s ? c : nxt;
      4'd8: call = 1'b1;
      4'd9: if (s) call = 1'b1; else m_state = nxt;
      4'd10: ret = 1'b1;
      4'd11: if (s) ret = 1'b1; else m_state = nxt;
      default: m_state = nxt;
    endcase
    if (call) begin
      if (m_stack.size() == DEPTH) m_ovf = 1'b1;
      else m_stack.push_back(nxt);
      m_state = c;
    end
    if (ret) begin
      if (m_stack.size() == 0) begin
        m_state = FETCH_ADDR;
        m_unf   = 1'b1;
      end else begin
        m_state = m_stack.pop_back();
      end
    end
  endfunction

  task automatic cyc(logic ld, logic [3:0] op, logic [3:0] ci, logic [1:0] cs,
                     logic iv, int en, int c);
    d_cond = ci; d_sel = cs; d_inv = iv;
    bus.ld = ld; bus.n_op = op; bus.cond_in = ci; bus.cond_sel = cs;
    bus.inv = iv; bus.enc = STATE_W'(en); bus.cr = STATE_W'(c);
    @(posedge clk);
    if (!reset) begin
      model_edge(ld, op, ci, cs, iv, en, c);
      exp_q.push_back(STATE_W'(m_state));
    end
    #1;
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_state"}, int'(bus.state), RESET_ADDR);
    chk({tag, "_sp"},    int'(bus.sp), 0);
    chk({tag, "_ovf"},   int'(bus.ovf), 0);
    chk({tag, "_unf"},   int'(bus.unf), 0);
  endtask

  // Reset asserted between edges with a call pending on the inputs.
  task automatic reset_mid(string tag);
    d_cond = 4'($urandom_range(0, 15));
    bus.ld = 1'b1; bus.n_op = 4'd8; bus.cr = STATE_W'($urandom_range(0, 127));
    bus.cond_in = d_cond;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_reset_vals(tag);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [STATE_W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", int'(bus.state), int'(e));
    end
    chk("sp",  int'(bus.sp), m_stack.size());
    chk("ovf", int'(bus.ovf), int'(m_ovf));
    chk("unf", int'(bus.unf), int'(m_unf));
    chk("sts", int'(bus.sts), int'(d_cond[d_sel] ^ d_inv));
  end

  initial begin
    bus.ld = 1'b0; bus.n_op = 4'd0; bus.cond_in = '0; bus.cond_sel = '0;
    bus.inv = 1'b0; bus.enc = '0; bus.cr = '0;
    #2;
    check_reset_vals("por");
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;

    // Sequential increment and wrap.
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 4'd3, 4'd0, 2'd0, 0, 0, 0);
      chk("inc_seq", int'(bus.state), i);
    end
    cyc(1, 4'd0, 4'd0, 2'd0, 0, 127, 0);
    cyc(1, 4'd3, 4'd0, 2'd0, 0, 0, 0);
    chk("inc_wrap", int'(bus.state), 0);

    // Conditional select enc/cr.
    cyc(1, 4'd4, 4'b0100, 2'd2, 0, 9, 8);
    chk("cond_true", int'(bus.state), 9);
    cyc(1, 4'd4, 4'b0100, 2'd2, 1, 9, 8);
    chk("cond_inv", int'(bus.state), 8);

    // Call / return pair.
    cyc(1, 4'd0, 4'd0, 2'd0, 0, 10, 0);
    cyc(1, 4'd8, 4'd0, 2'd0, 0, 0, 40);
    chk("call_state", int'(bus.state), 40);
    chk("call_sp", int'(bus.sp), 1);
    cyc(1, 4'd10, 4'd0, 2'd0, 0, 0, 0);
    chk("ret_state", int'(bus.state), 11);
    chk("ret_sp", int'(bus.sp), 0);

    // Overflow: five nested calls then four returns.
    cyc(1, 4'd0, 4'd0, 2'd0, 0, 5, 0);
    for (int i = 0; i < 5; i++) cyc(1, 4'd8, 4'd0, 2'd0, 0, 0, 20 + 10 * i);
    chk("ovf_state", int'(bus.state), 60);
    chk("ovf_sp", int'(bus.sp), 4);
    chk("ovf_flag", int'(bus.ovf), 1);
    cyc(1, 4'd10, 4'd0, 2'd0, 0, 0, 0); chk("unwind1", int'(bus.state), 41);
    cyc(1, 4'd10, 4'd0, 2'd0, 0, 0, 0); chk("unwind2", int'(bus.state), 31);
    cyc(1, 4'd10, 4'd0, 2'd0, 0, 0, 0); chk("unwind3", int'(bus.state), 21);
    cyc(1, 4'd10, 4'd0, 2'd0, 0, 0, 0); chk("unwind4", int'(bus.state), 6);
    chk("unwind_sp", int'(bus.sp), 0);

    // Underflow, then ld=0 holds everything.
    cyc(1, 4'd10, 4'd0, 2'd0, 0, 0, 0);
    chk("unf_state", int'(bus.state), FETCH_ADDR);
    chk("unf_flag", int'(bus.unf), 1);
    chk("unf_sp", int'(bus.sp), 0);
    chk("ovf_sticky", int'(bus.ovf), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'($urandom_range(0, 15)), 4'hF, 2'($urandom_range(0, 3)), 0,
          $urandom_range(0, 127), $urandom_range(0, 127));
      chk("hold_state", int'(bus.state), FETCH_ADDR);
      chk("hold_unf", int'(bus.unf), 1);
    end

    // Reset in the middle of a call sequence.
    cyc(1, 4'd8, 4'd0, 2'd0, 0, 0, 30);
    cyc(1, 4'd8, 4'd0, 2'd0, 0, 0, 50);
    reset_mid("mid_rst");
    cyc(1, 4'd10, 4'd0, 2'd0, 0, 0, 0);
    chk("post_rst_ret", int'(bus.state), FETCH_ADDR);

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_mid("rand_rst");
      end else begin
        cyc(logic'($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            logic'($urandom_range(0, 1)), $urandom_range(0, 127),
            $urandom_range(0, 127));
      end
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 Parameter STATE_W, 7, width of the control-store address (state).
REQ-002 Parameter NCOND, 4, number of condition inputs (power of two, >=2).
REQ-003 Parameter DEPTH, 4, return-address stack entries (>=1).
REQ-004 Parameter FETCH_ADDR, 1, hard-coded fetch state address.
REQ-005 Parameter RESET_ADDR, 0, state after reset.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 ld  input  1  advance enable; low = hold state and stack.
REQ-009 n_op  input  4  next-address operation code.
REQ-010 cond_in  input  NCOND  condition sources (MOC, COND, DMOC, ...).
REQ-011 cond_sel  input  clog2(NCOND)  selects the tested condition.
REQ-012 inv  input  1  inverts the selected condition.
REQ-013 enc  input  STATE_W  encoder (opcode-decoded) target address.
REQ-014 cr  input  STATE_W  control-register jump/call target.
REQ-015 state  output  STATE_W  current state, registered.
REQ-016 sp  output  clog2(DEPTH+1)  stack occupancy, registered.
REQ-017 ovf  output  1  sticky stack-overflow flag, registered.
REQ-018 unf  output  1  sticky stack-underflow flag, registered.

Function
REQ-019 sts SHALL equal cond_in[cond_sel] XOR inv, combinational, same cycle.
REQ-020 inc SHALL equal state+1 modulo 2^STATE_W (all-ones wraps to 0).
REQ-021 On rising clk with ld=1, state SHALL load next per n_op: 0000 enc; 0001 FETCH_ADDR; 0010 cr; 0011 inc; 0100 sts?enc:cr; 0101 sts?FETCH_ADDR:cr; 0110 sts?inc:FETCH_ADDR.
REQ-022 0111: sts?cr:inc (conditional branch); 1000: call cr unconditionally; 1001: sts?call cr:inc.
REQ-023 1010: return unconditionally; 1011: sts?return:inc; 1100-1111: inc (reserved, no stack effect).
REQ-024 Call SHALL push inc onto stack top, sp+1, and load cr; latency one clock.
REQ-025 Return SHALL load the top entry, pop it, sp-1; latency one clock.
REQ-026 Call with sp==DEPTH SHALL still load cr, leave stack and sp unchanged, set ovf.
REQ-027 Return with sp==0 SHALL load FETCH_ADDR, leave sp at 0, set unf.
REQ-028 Untaken conditional call/return SHALL not touch stack, sp or flags.
REQ-029 ld=0 SHALL hold state, sp, stack contents and flags regardless of n_op.
REQ-030 ovf/unf SHALL be cleared only by reset; once set stay set.
REQ-031 Stack SHALL be LIFO; nested calls return in reverse order.

Reset
REQ-032 reset high SHALL immediately (no clock) force state=RESET_ADDR, sp=0, ovf=0, unf=0.
REQ-033 Stack entry contents need no reset; only sp defines validity.
REQ-034 Reset asserted mid-call/return SHALL abort it; first edge after deassert uses normal rules.

Verification
REQ-035 Reset then n_op=0011, ld=1, 5 clocks -> state 0,1,2,3,4,5; state=127 with 0011 -> 0.
REQ-036 cond_in=0100, cond_sel=2, inv=0, n_op=0100, enc=9, cr=8 -> state 9; inv=1 -> state 8.
REQ-037 state=10, n_op=1000, cr=40 -> state 40, sp=1; then n_op=1010 -> state 11, sp=0.
REQ-038 Five consecutive calls (DEPTH=4) -> fifth jumps, sp stays 4, ovf=1; four returns unwind correctly.
REQ-039 sp=0, n_op=1010 -> state=1 (FETCH_ADDR), unf=1, sp=0; ld=0 any n_op -> nothing changes.
REQ-040 Assert reset between clock edges during call sequence -> state=0, sp=0, flags 0 immediately.
